// File: rtl/program_loader.sv
// program_loader: target end of the host program-download protocol.
// Sends HELLO_BYTE, takes a 32-bit little-endian byte count, writes the
// program words to IMEM, then sends READY_BYTE and raises done.
// Optional build macro LOADER_CHECKSUM_EN adds an 8-bit XOR checksum of the
// program bytes, transmitted between the program and READY_BYTE.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [7:0]  HELLO_BYTE = 8'h99,
  parameter logic [7:0]  READY_BYTE = 8'haa
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rdata,
  input  logic                  ferr,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            sdata,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_HELLO,
    S_SIZE,
    S_PROG,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_READY,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest legal byte count: the whole IMEM.
  localparam logic [32:0]         MAX_BYTES = 33'(1) << (ADDR_WIDTH + 2);
  localparam logic [ADDR_WIDTH:0] ONE_WORD  = 1;

  state_t                r_state;
  state_t                w_next_state;
  logic [23:0]           r_size_lo;     // first three size bytes
  logic [ADDR_WIDTH:0]   r_words;       // program length in words
  logic [31:0]           r_word;        // word being assembled
  logic [1:0]            r_byte_cnt;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_imem_we;
  logic                  r_tx_prev;     // tx_start of the previous cycle
  logic [7:0]            r_sdata;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_can_send;
  logic                  w_tx_fire;
  logic [7:0]            w_tx_byte;
  logic                  w_rx_ok;
  logic                  w_rx_bad;
  logic [31:0]           w_size_full;
  logic                  w_last_byte;

  // A new send needs an idle transmitter and a gap cycle after the last pulse.
  assign w_can_send  = ~reset & ~tx_busy & ~r_tx_prev;
  assign w_rx_ok     = rx_ready & ~ferr;
  assign w_rx_bad    = rx_ready & ferr;
  assign w_size_full = {rdata, r_size_lo};
  assign w_last_byte = (r_byte_cnt == 2'd3);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked branch
    // rather than in the sensitivity list.
    if (reset) r_state <= S_HELLO;
    else       r_state <= w_next_state;
  end

  // Next-state and transmit decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_next_state = r_state;
    w_tx_fire    = 1'b0;
    w_tx_byte    = r_sdata;
    case (r_state)
      S_HELLO: begin
        w_tx_byte = HELLO_BYTE;
        if (w_can_send) begin
          w_tx_fire    = 1'b1;
          w_next_state = S_SIZE;
        end
      end
      S_SIZE: begin
        if (w_rx_bad) begin
          w_next_state = S_ERROR;
        end else if (w_rx_ok && w_last_byte) begin
          if (w_size_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            w_next_state = S_CSUM;
`else
            w_next_state = S_READY;
`endif
          end else if ((w_size_full[1:0] != 2'd0) || ({1'b0, w_size_full} > MAX_BYTES)) begin
            w_next_state = S_ERROR;
          end else begin
            w_next_state = S_PROG;
          end
        end
      end
      S_PROG: begin
        if (w_rx_bad) begin
          w_next_state = S_ERROR;
        end else if (r_imem_we && (r_word_count + ONE_WORD == r_words)) begin
`ifdef LOADER_CHECKSUM_EN
          w_next_state = S_CSUM;
`else
          w_next_state = S_READY;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        w_tx_byte = r_csum;
        if (w_can_send) begin
          w_tx_fire    = 1'b1;
          w_next_state = S_READY;
        end
      end
`endif
      S_READY: begin
        w_tx_byte = READY_BYTE;
        if (w_can_send) begin
          w_tx_fire    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_DONE;
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = S_HELLO;
    endcase
  end

  // Datapath: size capture, word assembly, IMEM write pulse, transmit hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_size_lo    <= '0;
      r_words      <= '0;
      r_word       <= '0;
      r_byte_cnt   <= '0;
      r_word_count <= '0;
      r_imem_we    <= 1'b0;
      r_tx_prev    <= 1'b0;
      r_sdata      <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_tx_prev <= w_tx_fire;
      r_imem_we <= 1'b0;
      if (w_tx_fire) r_sdata <= w_tx_byte;
      if (r_imem_we) r_word_count <= r_word_count + ONE_WORD;
      if (w_rx_ok && (r_state == S_SIZE)) begin
        r_size_lo  <= w_size_full[31:8];
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (w_last_byte) r_words <= w_size_full[ADDR_WIDTH+2:2];
      end
      if (w_rx_ok && (r_state == S_PROG)) begin
        r_word     <= {rdata, r_word[31:8]};
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (w_last_byte) r_imem_we <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        r_csum     <= r_csum ^ rdata;
`endif
      end
    end
  end

  assign tx_start   = w_tx_fire;
  assign sdata      = w_tx_fire ? w_tx_byte : r_sdata;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_word_count[ADDR_WIDTH-1:0];
  assign imem_wdata = r_word;
  assign word_count = r_word_count;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected transmit
// bytes and IMEM writes into queues, a negedge monitor pops and compares.
module tb_program_loader;
  localparam int AW = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rdata = 8'h00;
  logic          ferr = 1'b0;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    sdata;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          done;
  logic          error;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .rx_ready(rx_ready), .rdata(rdata),
    .ferr(ferr), .tx_busy(tx_busy), .tx_start(tx_start), .sdata(sdata),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];
  int         n_checks = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // UART transmitter model: busy for 20 cycles after each start pulse.
  initial forever begin
    @(negedge clock);
    if (tx_start && !reset) begin
      @(posedge clock);
      #1 tx_busy = 1'b1;
      repeat (20) @(posedge clock);
      #1 tx_busy = 1'b0;
    end
  end

  // Monitor: compare every transmit and every IMEM write with the scoreboard.
  always @(negedge clock) begin
    if (!reset && tx_start) begin
      check("tx_while_busy", 32'(tx_busy), 32'd0);
      if (exp_tx.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL tx_unexpected: got %02h required none", sdata);
      end else begin
        logic [7:0] e;
        e = exp_tx.pop_front();
        check("tx_byte", 32'(sdata), 32'(e));
      end
    end
    if (!reset && imem_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL wr_unexpected: got addr %0h data %08h required none", imem_addr, imem_wdata);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(w.addr));
        check("wr_data", imem_wdata, w.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic f = 1'b0);
    rx_ready = 1'b1;
    rdata    = b;
    ferr     = f;
    tick();
    rx_ready = 1'b0;
    ferr     = 1'b0;
    tick(11);
  endtask

  task automatic send_size(input logic [31:0] s);
    for (int i = 0; i < 4; i++) send_byte(s[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] addr);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_wr.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  // Reset, check cleared outputs, then expect the hello byte.
  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    exp_tx.delete();
    exp_wr.delete();
    exp_tx.push_back(8'h99);
    reset = 1'b0;
    tick(5);
  endtask

  // Wait (bounded) for done/error, let stray activity show, then check.
  task automatic finish_check(input string name, input logic d, input logic e, input int wc);
    int n;
    n = 0;
    while (!done && !error && n < 300) begin
      tick();
      n++;
    end
    tick(40);
    check({name, "_done"}, 32'(done), 32'(d));
    check({name, "_error"}, 32'(error), 32'(e));
    check({name, "_word_count"}, 32'(word_count), 32'(wc));
    check({name, "_tx_pending"}, exp_tx.size(), 32'd0);
    check({name, "_wr_pending"}, exp_wr.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: two-word program.
    do_reset();
`ifdef LOADER_CHECKSUM_EN
    exp_tx.push_back(8'h66);
`endif
    exp_tx.push_back(8'haa);
    send_size(32'd8);
    send_word(32'h11223344, 0);
    send_word(32'hdeadbeef, 1);
    finish_check("t1", 1'b1, 1'b0, 2);
    // Bytes after done are ignored.
    for (int i = 0; i < 4; i++) send_byte(8'h5a);
    finish_check("t1_ignore", 1'b1, 1'b0, 2);

    // T2: empty program.
    do_reset();
`ifdef LOADER_CHECKSUM_EN
    exp_tx.push_back(8'h00);
`endif
    exp_tx.push_back(8'haa);
    send_size(32'd0);
    finish_check("t2", 1'b1, 1'b0, 0);

    // T3: size not a multiple of 4.
    do_reset();
    send_size(32'd6);
    finish_check("t3", 1'b0, 1'b1, 0);

    // Size one word beyond IMEM capacity.
    do_reset();
    send_size(32'h0002_0004);
    finish_check("t3_cap", 1'b0, 1'b1, 0);

    // T4: framing error on the 3rd byte of word 1.
    do_reset();
    send_size(32'd8);
    send_word(32'hcafef00d, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04);
    finish_check("t4", 1'b0, 1'b1, 1);

    // T5: reset in the middle of the program, then a full reload.
    do_reset();
    send_size(32'd8);
    send_word(32'h0badf00d, 0);
    send_byte(8'h77);
    send_byte(8'h88);
    do_reset();
`ifdef LOADER_CHECKSUM_EN
    exp_tx.push_back(8'h66);
`endif
    exp_tx.push_back(8'haa);
    send_size(32'd8);
    send_word(32'h11223344, 0);
    send_word(32'hdeadbeef, 1);
    finish_check("t5", 1'b1, 1'b0, 2);

    // T6: checksum vector (0x01^0x02^0x03^0x04^0xff = 0xfb).
    do_reset();
`ifdef LOADER_CHECKSUM_EN
    exp_tx.push_back(8'hfb);
`endif
    exp_tx.push_back(8'haa);
    send_size(32'd8);
    send_word(32'h01020304, 0);
    send_word(32'h000000ff, 1);
    finish_check("t6", 1'b1, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
